lcd_frame_arbiter: RTL and testbench

Frame-level arbiter that shares the single LCD byte path (the LCD controller's data / data_valid / en_tran handshake) between two byte-stream renderers: source 0, the game-board renderer, and source 1, the status/score renderer. It grants one source a whole frame at a time, round-robin, and forwards its bytes and the controller's transfer enable. It counts bytes to frame completion and aborts a frame whose source stalls. It sits on the LCD clock domain, between the renderers and the LCD controller.

---
 rtl/lcd_frame_arbiter.sv | 115 +++++++++++
 tb/tb_lcd_frame_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_arbiter.sv
// Frame-level round-robin arbiter sharing one LCD byte path between two renderers.
// Grants a whole frame, forwards the byte handshake, and aborts stalled frames.
module lcd_frame_arbiter #(
  parameter int FRAME_BYTES = 1024,
  parameter int CNT_W       = 11,
  parameter int TIMEOUT     = 4095,
  parameter int TO_W        = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] src0_data,
  input  logic [7:0] src1_data,
  input  logic       src0_valid,
  input  logic       src1_valid,
  output logic       src0_en,
  output logic       src1_en,
  output logic [1:0] gnt,
  output logic [7:0] lcd_data,
  output logic       lcd_data_valid,
  input  logic       lcd_en_tran,
  output logic       busy,
  output logic       frame_done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BYTES - 1);
  localparam logic [TO_W-1:0]  LAST_STALL = TO_W'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic              last_src;
  logic [CNT_W-1:0]  beat_cnt;
  logic [TO_W-1:0]   stall_cnt;
  logic              xfer;
  logic              sel_valid;
  logic              beat;
  logic              last_beat;
  logic              stall_hit;
  logic              win1;

  // Combinational pass-through from the granted source
  always_comb begin
    xfer      = (state == XFER);
    sel_valid = gnt[1] ? src1_valid : src0_valid;
    beat      = xfer && lcd_en_tran && sel_valid;
    last_beat = beat && (beat_cnt == LAST_BEAT);
    stall_hit = xfer && !beat && (stall_cnt == LAST_STALL);
    // On a tie the source that did not win last time goes next.
    win1      = (req == 2'b11) ? ~last_src : req[1];

    busy           = xfer;
    lcd_data       = xfer ? (gnt[1] ? src1_data : src0_data) : 8'h00;
    lcd_data_valid = xfer && sel_valid;
    src0_en        = xfer && lcd_en_tran && gnt[0];
    src1_en        = xfer && lcd_en_tran && gnt[1];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req != 2'b00) state_nxt = XFER;
      XFER:    if (last_beat || stall_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered control: state, grant, counters and completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      last_src   <= 1'b1;
      beat_cnt   <= '0;
      stall_cnt  <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= last_beat;
      err        <= stall_hit;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            gnt       <= win1 ? 2'b10 : 2'b01;
            last_src  <= win1;
            beat_cnt  <= '0;
            stall_cnt <= '0;
          end
        end
        XFER: begin
          if (beat) begin
            beat_cnt  <= beat_cnt + CNT_W'(1);
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + TO_W'(1);
          end
          if (last_beat || stall_hit) gnt <= 2'b00;
        end
        default: begin
          gnt       <= 2'b00;
          beat_cnt  <= '0;
          stall_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Bench for lcd_frame_arbiter: directed frames, a pass-through vector table,
// and random traffic checked every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_lcd_frame_arbiter;
  localparam int FB = 1024;
  localparam int TO = 4095;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] src0_data, src1_data;
  logic       src0_valid, src1_valid, lcd_en_tran;
  logic       src0_en, src1_en;
  logic [1:0] gnt;
  logic [7:0] lcd_data;
  logic       lcd_data_valid, busy, frame_done, err;

  always #5 clk = ~clk;

  lcd_frame_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .src0_data(src0_data), .src1_data(src1_data),
    .src0_valid(src0_valid), .src1_valid(src1_valid),
    .src0_en(src0_en), .src1_en(src1_en), .gnt(gnt),
    .lcd_data(lcd_data), .lcd_data_valid(lcd_data_valid),
    .lcd_en_tran(lcd_en_tran), .busy(busy),
    .frame_done(frame_done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: who owns the path, bytes delivered, idle run, pending pulse
  int m_owner = -1;
  int m_beats = 0;
  int m_stall = 0;
  int m_post  = 0;
  int m_last  = 1;

  int n_en0, n_en1, n_beat, n_done, n_err;
  bit keep_data = 0;
  bit obs_end;

  typedef struct packed {
    logic       en;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic [7:0] x_data;
    logic       x_valid;
    logic       x_en0;
    logic       x_en1;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] obs();
    return {gnt, busy, lcd_data, lcd_data_valid, src0_en, src1_en, frame_done, err};
  endfunction

  function automatic logic [15:0] expect_vec();
    logic [1:0] g;
    logic       b, v, e0, e1, fd, er;
    logic [7:0] d;
    g = 2'b00; b = 0; v = 0; e0 = 0; e1 = 0; fd = 0; er = 0; d = 8'h00;
    if (!rst) begin
      if (m_owner >= 0) begin
        g  = (m_owner == 1) ? 2'b10 : 2'b01;
        b  = 1;
        d  = (m_owner == 1) ? src1_data : src0_data;
        v  = (m_owner == 1) ? src1_valid : src0_valid;
        e0 = lcd_en_tran && (m_owner == 0);
        e1 = lcd_en_tran && (m_owner == 1);
      end else begin
        fd = (m_post == 1);
        er = (m_post == 2);
      end
    end
    return {g, b, d, v, e0, e1, fd, er};
  endfunction

  task automatic model_step();
    bit bt;
    int w;
    if (rst) begin
      m_owner = -1; m_beats = 0; m_stall = 0; m_post = 0; m_last = 1;
    end else if (m_owner >= 0) begin
      bt = lcd_en_tran && ((m_owner == 1) ? src1_valid : src0_valid);
      if (bt) begin
        m_beats++;
        m_stall = 0;
        if (m_beats == FB) begin m_post = 1; m_owner = -1; end
      end else begin
        m_stall++;
        if (m_stall == TO) begin m_post = 2; m_owner = -1; end
      end
    end else if (m_post != 0) begin
      m_post = 0;
    end else if (req != 2'b00) begin
      w = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
      m_last = w; m_owner = w; m_beats = 0; m_stall = 0;
    end
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic cycle();
    if (!keep_data) begin
      src0_data = 8'($urandom);
      src1_data = 8'($urandom);
    end
    #1;
    chk("cycle_outputs", 32'(obs()), 32'(expect_vec()));
    if (src0_en) n_en0++;
    if (src1_en) n_en1++;
    if ((src0_en && src0_valid) || (src1_en && src1_valid)) n_beat++;
    if (frame_done) n_done++;
    if (err) n_err++;
    obs_end = frame_done || err;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic clr();
    n_en0 = 0; n_en1 = 0; n_beat = 0; n_done = 0; n_err = 0;
  endtask

  task automatic run_to_end(input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!obs_end && n < budget);
    chk("frame_end_seen", 32'(obs_end), 32'(1));
  endtask

  task automatic do_reset();
    rst = 1; req = 2'b00; src0_valid = 0; src1_valid = 0; lcd_en_tran = 0;
    cycle();
    cycle();
    rst = 0;
    chk("reset_state", 32'(obs()), 32'(0));
  endtask

  int n;
  int i;
  logic [1:0] g_seen [3];

  initial begin
    rst = 1; req = 2'b00; src0_valid = 0; src1_valid = 0; lcd_en_tran = 0;
    src0_data = 8'h00; src1_data = 8'h00;
    //            en  v0  d0     v1  d1     xdata  xv  xe0 xe1
    tbl[0] = '{1'b1, 1'b1, 8'hA5, 1'b1, 8'h3C, 8'hA5, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'h5A, 1'b1, 8'h3C, 8'h5A, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'hFF, 1'b1, 8'h11, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'h81, 1'b0, 8'h99, 8'h81, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 8'h7E, 1'b1, 8'h7E, 8'h7E, 1'b1, 1'b1, 1'b0};
    @(negedge clk);

    // Single source, zero-stall frame
    do_reset();
    clr();
    req = 2'b01; src0_valid = 1; src1_valid = 1; lcd_en_tran = 1;
    cycle();
    chk("s1_gnt", 32'(gnt), 32'(2'b01));
    req = 2'b00;
    run_to_end(FB + 10, n);
    chk("s1_len", n, FB + 1);
    chk("s1_en0", n_en0, FB);
    chk("s1_en1", n_en1, 0);
    chk("s1_done", n_done, 1);
    cycle();

    // Both requesting: round-robin over three frames
    do_reset();
    clr();
    req = 2'b11; src0_valid = 1; src1_valid = 1; lcd_en_tran = 1;
    for (int f = 0; f < 3; f++) begin
      cycle();
      g_seen[f] = gnt;
      run_to_end(FB + 10, n);
    end
    req = 2'b00;
    cycle();
    chk("s2_order0", 32'(g_seen[0]), 32'(2'b01));
    chk("s2_order1", 32'(g_seen[1]), 32'(2'b10));
    chk("s2_order2", 32'(g_seen[2]), 32'(2'b01));
    chk("s2_en0", n_en0, 2 * FB);
    chk("s2_en1", n_en1, FB);
    chk("s2_done", n_done, 3);

    // src0 with vector table, toggling enable and a valid gap
    clr();
    req = 2'b01; src0_valid = 1; src1_valid = 1; lcd_en_tran = 1;
    cycle();
    chk("s3_gnt", 32'(gnt), 32'(2'b01));
    req = 2'b00;
    keep_data = 1;
    for (int r = 0; r < 6; r++) begin
      lcd_en_tran = tbl[r].en;
      src0_valid = tbl[r].v0; src0_data = tbl[r].d0;
      src1_valid = tbl[r].v1; src1_data = tbl[r].d1;
      #1;
      chk($sformatf("s3_vec%0d", r),
          32'({lcd_data, lcd_data_valid, src0_en, src1_en}),
          32'({tbl[r].x_data, tbl[r].x_valid, tbl[r].x_en0, tbl[r].x_en1}));
      cycle();
    end
    keep_data = 0;
    i = 0;
    obs_end = 0;
    while (!obs_end && i < 4000) begin
      lcd_en_tran = (i % 2) == 0;
      src0_valid = !(i >= 300 && i < 310);
      src1_valid = $urandom_range(0, 1);
      cycle();
      i++;
    end
    chk("s3_end_seen", 32'(obs_end), 32'(1));
    chk("s3_beats", n_beat, FB);
    chk("s3_err", n_err, 0);
    chk("s3_done", n_done, 1);
    cycle();

    // src1 stalls after 300 beats and times out
    clr();
    req = 2'b10; src1_valid = 1; src0_valid = 1; lcd_en_tran = 1;
    cycle();
    chk("s4_gnt", 32'(gnt), 32'(2'b10));
    req = 2'b00;
    repeat (300) cycle();
    src1_valid = 0;
    run_to_end(TO + 50, n);
    chk("s4_stall_len", n, TO + 1);
    chk("s4_err", n_err, 1);
    chk("s4_done", n_done, 0);
    chk("s4_beats", n_beat, 300);
    cycle();
    req = 2'b01; src0_valid = 1;
    cycle();
    chk("s4_next_gnt", 32'(gnt), 32'(2'b01));
    req = 2'b00;
    run_to_end(FB + 10, n);
    chk("s4_next_done", n_done, 1);
    cycle();

    // req dropped five cycles into the frame
    clr();
    req = 2'b01; src0_valid = 1; lcd_en_tran = 1;
    cycle();
    repeat (5) cycle();
    req = 2'b00;
    run_to_end(FB + 10, n);
    chk("s5_done", n_done, 1);
    chk("s5_beats", n_beat, FB);
    chk("s5_err", n_err, 0);
    cycle();

    // Reset mid-frame, then tie goes to src0
    clr();
    req = 2'b10; src1_valid = 1; lcd_en_tran = 1;
    cycle();
    req = 2'b00;
    repeat (500) cycle();
    rst = 1;
    #1;
    chk("s6_rst_outputs", 32'(obs()), 32'(0));
    cycle();
    rst = 0;
    cycle();
    req = 2'b11; src0_valid = 1;
    cycle();
    chk("s6_tie_gnt", 32'(gnt), 32'(2'b01));
    req = 2'b00;
    run_to_end(FB + 10, n);
    chk("s6_done", n_done, 1);
    chk("s6_err", n_err, 0);
    cycle();

    // Random traffic against the model
    for (int k = 0; k < 15000; k++) begin
      req = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      src0_valid = $urandom_range(0, 9) < 7;
      src1_valid = $urandom_range(0, 9) < 7;
      lcd_en_tran = $urandom_range(0, 9) < 7;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
